// File: rtl/idex_skid_stage.sv
// Decode-to-execute stage: two-entry skid buffer with valid/ready handshake
// and a load-use interlock that holds dependents for LOAD_BUBBLES cycles.
module idex_skid_stage #(
   parameter int PAYLOAD_WIDTH = 160,
   parameter int RADDR_WIDTH   = 5,
   parameter int LOAD_BUBBLES  = 1
) (
   input  logic                     Clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   input  logic [RADDR_WIDTH-1:0]   in_rd,
   input  logic                     in_rd_we,
   input  logic                     in_is_load,
   input  logic [RADDR_WIDTH-1:0]   in_rs1,
   input  logic [RADDR_WIDTH-1:0]   in_rs2,
   input  logic                     in_need_rs1,
   input  logic                     in_need_rs2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_WIDTH-1:0] out_payload,
   output logic [RADDR_WIDTH-1:0]   out_rd,
   output logic                     out_rd_we,
   output logic                     out_is_load,
   output logic                     hazard_stall,
   output logic [1:0]               occupancy
);

   typedef struct packed {
      logic [PAYLOAD_WIDTH-1:0] payload;
      logic [RADDR_WIDTH-1:0]   rd;
      logic                     rdWe;
      logic                     isLoad;
      logic [RADDR_WIDTH-1:0]   rs1;
      logic [RADDR_WIDTH-1:0]   rs2;
      logic                     needRs1;
      logic                     needRs2;
   } entry_t;

   localparam logic [2:0] LdInit = 3'(LOAD_BUBBLES);

   entry_t                 inEntry;
   entry_t                 mEntry;
   entry_t                 sEntry;
   logic                   mValid;
   logic                   sValid;
   logic [RADDR_WIDTH-1:0] ldRd;
   logic [2:0]             ldCnt;
   logic                   rs1Hit;
   logic                   rs2Hit;
   logic                   hazard;
   logic                   inFire;
   logic                   outFire;
   logic                   loadFire;

   assign inEntry = '{
      payload: in_payload,
      rd:      in_rd,
      rdWe:    in_rd_we,
      isLoad:  in_is_load,
      rs1:     in_rs1,
      rs2:     in_rs2,
      needRs1: in_need_rs1,
      needRs2: in_need_rs2
   };

   // x0 is hard-wired, so a match on it is never a real dependency
   assign rs1Hit = mEntry.needRs1 && (mEntry.rs1 == ldRd)
                   && (mEntry.rs1 != '0);
   assign rs2Hit = mEntry.needRs2 && (mEntry.rs2 == ldRd)
                   && (mEntry.rs2 != '0);
   assign hazard = mValid && (ldCnt != 3'd0) && (rs1Hit || rs2Hit);

   assign hazard_stall = hazard;
   assign out_valid    = mValid && !hazard;
   assign outFire      = out_valid && out_ready;
   assign in_ready     = !sValid;
   assign inFire       = in_valid && !sValid && !flush;
   assign loadFire     = outFire && mEntry.isLoad && mEntry.rdWe
                         && (mEntry.rd != '0);

   assign out_payload = mEntry.payload;
   assign out_rd      = mEntry.rd;
   assign out_rd_we   = mEntry.rdWe;
   assign out_is_load = mEntry.isLoad;
   assign occupancy   = {1'b0, mValid} + {1'b0, sValid};

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         mValid <= 1'b0;
         sValid <= 1'b0;
         mEntry <= '0;
         sEntry <= '0;
      end else if (flush) begin
         mValid <= 1'b0;
         sValid <= 1'b0;
      end else if (outFire && sValid) begin
         mEntry <= sEntry;
         sValid <= 1'b0;
      end else if (inFire) begin
         if (!mValid || outFire) begin
            mEntry <= inEntry;
            mValid <= 1'b1;
         end else begin
            sEntry <= inEntry;
            sValid <= 1'b1;
         end
      end else if (outFire) begin
         mValid <= 1'b0;
      end
   end

   // the departing load is older than any flush, so tracking ignores flush
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         ldRd  <= '0;
         ldCnt <= 3'd0;
      end else if (loadFire) begin
         ldRd  <= mEntry.rd;
         ldCnt <= LdInit;
      end else if (ldCnt != 3'd0) begin
         ldCnt <= ldCnt - 3'd1;
      end
   end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Bench for idex_skid_stage: two instances (1 and 3 load bubbles)
// checked every cycle against a queue-based reference model.
module tb_idex_skid_stage;

   localparam int PW = 160;
   localparam int RW = 5;

   logic          Clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_payload = '0;
   logic [RW-1:0] in_rd = '0;
   logic          in_rd_we = 1'b0;
   logic          in_is_load = 1'b0;
   logic [RW-1:0] in_rs1 = '0;
   logic [RW-1:0] in_rs2 = '0;
   logic          in_need_rs1 = 1'b0;
   logic          in_need_rs2 = 1'b0;
   logic          out_ready = 1'b0;

   logic [1:0]          inRdy;
   logic [1:0]          oV;
   logic [1:0]          oWe;
   logic [1:0]          oLd;
   logic [1:0]          haz;
   logic [1:0][PW-1:0]  oPay;
   logic [1:0][RW-1:0]  oRd;
   logic [1:0][1:0]     occ;

   always #5 Clk = ~Clk;

   idex_skid_stage #(.PAYLOAD_WIDTH(PW), .RADDR_WIDTH(RW), .LOAD_BUBBLES(1)) u1 (
      .Clk(Clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(inRdy[0]), .in_payload(in_payload),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_need_rs1(in_need_rs1), .in_need_rs2(in_need_rs2),
      .out_valid(oV[0]), .out_ready(out_ready), .out_payload(oPay[0]),
      .out_rd(oRd[0]), .out_rd_we(oWe[0]), .out_is_load(oLd[0]),
      .hazard_stall(haz[0]), .occupancy(occ[0])
   );

   idex_skid_stage #(.PAYLOAD_WIDTH(PW), .RADDR_WIDTH(RW), .LOAD_BUBBLES(3)) u3 (
      .Clk(Clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(inRdy[1]), .in_payload(in_payload),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_need_rs1(in_need_rs1), .in_need_rs2(in_need_rs2),
      .out_valid(oV[1]), .out_ready(out_ready), .out_payload(oPay[1]),
      .out_rd(oRd[1]), .out_rd_we(oWe[1]), .out_is_load(oLd[1]),
      .hazard_stall(haz[1]), .occupancy(occ[1])
   );

   typedef struct {
      logic [PW-1:0] pay;
      logic [RW-1:0] rd;
      logic          we;
      logic          ld;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic          n1;
      logic          n2;
   } ent_t;

   ent_t          mq[2][$];
   int            tmr[2];
   logic [RW-1:0] lrd[2];
   int            lbs[2];
   int            total = 0;
   int            bad = 0;

   task automatic check(input string tag, input logic [PW-1:0] obs,
                        input logic [PW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit uses(ent_t e, logic [RW-1:0] r);
      if (r == '0) return 1'b0;
      return (e.n1 && e.rs1 == r) || (e.n2 && e.rs2 == r);
   endfunction

   task automatic setIn(input logic v, input logic [PW-1:0] p,
                        input logic [RW-1:0] rd, input logic we,
                        input logic ld, input logic [RW-1:0] r1,
                        input logic n1, input logic [RW-1:0] r2,
                        input logic n2);
      in_valid = v;    in_payload = p;  in_rd = rd;
      in_rd_we = we;   in_is_load = ld;
      in_rs1 = r1;     in_need_rs1 = n1;
      in_rs2 = r2;     in_need_rs2 = n2;
   endtask

   task automatic idle();
      setIn(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         tmr[m] = 0;
         lrd[m] = '0;
      end
   endtask

   // compares outputs with the model, then advances the model one edge
   task automatic modelCycle();
      for (int m = 0; m < 2; m++) begin
         int   sz;
         bit   h, v, of, inf;
         ent_t e;
         ent_t hd;
         string s;
         s  = $sformatf("lb%0d", lbs[m]);
         sz = mq[m].size();
         if (sz > 0) hd = mq[m][0];
         h  = (sz > 0) && (tmr[m] > 0) && uses(hd, lrd[m]);
         v  = (sz > 0) && !h;
         check({s, ".out_valid"}, oV[m], v);
         check({s, ".hazard"}, haz[m], h);
         check({s, ".in_ready"}, inRdy[m], sz < 2);
         check({s, ".occupancy"}, occ[m], sz);
         if (v) begin
            check({s, ".payload"}, oPay[m], hd.pay);
            check({s, ".rd"}, oRd[m], hd.rd);
            check({s, ".rd_we"}, oWe[m], hd.we);
            check({s, ".is_load"}, oLd[m], hd.ld);
         end
         of  = v && out_ready;
         inf = in_valid && (sz < 2) && !flush;
         if (of && hd.ld && hd.we && hd.rd != '0) begin
            lrd[m] = hd.rd;
            tmr[m] = lbs[m];
         end else if (tmr[m] > 0) begin
            tmr[m]--;
         end
         if (of) void'(mq[m].pop_front());
         if (flush) begin
            mq[m].delete();
         end else if (inf) begin
            e = '{in_payload, in_rd, in_rd_we, in_is_load,
                  in_rs1, in_rs2, in_need_rs1, in_need_rs2};
            mq[m].push_back(e);
         end
      end
   endtask

   task automatic cycle();
      modelCycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkResetVals(input string tag);
      for (int m = 0; m < 2; m++) begin
         check({tag, ".out_valid"}, oV[m], 1'b0);
         check({tag, ".in_ready"}, inRdy[m], 1'b1);
         check({tag, ".hazard"}, haz[m], 1'b0);
         check({tag, ".occupancy"}, occ[m], 2'd0);
         check({tag, ".payload"}, oPay[m], '0);
         check({tag, ".rd"}, oRd[m], '0);
         check({tag, ".rd_we"}, oWe[m], 1'b0);
         check({tag, ".is_load"}, oLd[m], 1'b0);
      end
   endtask

   // load (payload 100) then dependent (payload 101); counts bubbles
   task automatic pairTest(input string tag, input logic [RW-1:0] ldRd,
                           input logic [RW-1:0] r1, input logic n1,
                           input int e1, input int e3);
      int la[2];
      int da[2];
      int hz[2];
      int ex[2];
      ex[0] = e1;
      ex[1] = e3;
      for (int m = 0; m < 2; m++) begin
         la[m] = -100; da[m] = -1; hz[m] = 0;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) setIn(1'b1, 100, ldRd, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
         else if (i == 1) setIn(1'b1, 101, 5'd3, 1'b1, 1'b0, r1, n1, '0, 1'b0);
         else idle();
         for (int m = 0; m < 2; m++) begin
            if (oV[m] && oPay[m] == 100) la[m] = i;
            if (oV[m] && oPay[m] == 101) da[m] = i;
            if (haz[m]) hz[m]++;
         end
         cycle();
      end
      for (int m = 0; m < 2; m++) begin
         check($sformatf("%s.bubbles%0d", tag, m), da[m] - la[m] - 1, ex[m]);
         check($sformatf("%s.stalls%0d", tag, m), hz[m], ex[m]);
      end
   endtask

   initial begin
      logic [PW-1:0] got[$];
      bit            sent;
      lbs[0] = 1;
      lbs[1] = 3;
      modelReset();

      #1 reset = 1'b0;
      #1 checkResetVals("reset");
      @(posedge Clk);
      #1 reset = 1'b1;
      cycle();

      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         setIn(1'b1, k, 5'(k), 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
         cycle();
         check($sformatf("stream.v%0d", k), oV[0], 1'b1);
         check($sformatf("stream.p%0d", k), oPay[0], k);
         check($sformatf("stream.occ%0d", k), occ[0] <= 2'd1, 1'b1);
      end
      idle();
      cycle();
      cycle();

      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         setIn(1'b1, 20 + k, 5'd4, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
         cycle();
      end
      check("bp.occ", occ[0], 2'd2);
      check("bp.in_ready", inRdy[0], 1'b0);
      out_ready = 1'b1;
      sent = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (sent) idle();
         if (oV[0]) got.push_back(oPay[0]);
         if (in_valid && inRdy[0] && inRdy[1]) sent = 1'b1;
         cycle();
      end
      check("bp.count", got.size(), 3);
      for (int i = 0; i < got.size() && i < 3; i++)
         check($sformatf("bp.order%0d", i), got[i], 20 + i);

      pairTest("ilk", 5'd5, 5'd5, 1'b1, 1, 3);
      pairTest("x0", 5'd0, 5'd0, 1'b1, 0, 0);
      pairTest("noneed", 5'd5, 5'd5, 1'b0, 0, 0);

      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         setIn(1'b1, 30 + k, 5'd4, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
         cycle();
      end
      check("fl.pre", occ[0], 2'd2);
      flush = 1'b1;
      setIn(1'b1, 32, 5'd4, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      cycle();
      flush = 1'b0;
      idle();
      for (int m = 0; m < 2; m++) begin
         check($sformatf("fl.occ%0d", m), occ[m], 2'd0);
         check($sformatf("fl.v%0d", m), oV[m], 1'b0);
      end
      out_ready = 1'b1;
      cycle();
      setIn(1'b1, 40, 5'd7, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
      cycle();
      idle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      setIn(1'b1, 41, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, '0, 1'b0);
      cycle();
      idle();
      check("fl.dep.haz3", haz[1], 1'b1);
      check("fl.dep.haz1", haz[0], 1'b0);
      check("fl.dep.v1", oV[0], 1'b1);
      repeat (6) cycle();

      setIn(1'b1, 50, 5'd9, 1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
      cycle();
      setIn(1'b1, 51, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, '0, 1'b0);
      cycle();
      out_ready = 1'b0;
      setIn(1'b1, 52, 5'd2, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      cycle();
      idle();
      check("rst.pre.occ", occ[0], 2'd2);
      check("rst.pre.haz3", haz[1], 1'b1);
      #2 reset = 1'b0;
      #1 checkResetVals("rstmid");
      modelReset();
      reset = 1'b1;
      out_ready = 1'b1;
      setIn(1'b1, 53, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, '0, 1'b0);
      cycle();
      idle();
      for (int m = 0; m < 2; m++) begin
         check($sformatf("rst.post.v%0d", m), oV[m], 1'b1);
         check($sformatf("rst.post.haz%0d", m), haz[m], 1'b0);
         check($sformatf("rst.post.p%0d", m), oPay[m], 53);
      end
      cycle();

      for (int i = 0; i < 3000; i++) begin
         setIn($urandom_range(99) < 70, PW'($urandom),
               5'($urandom_range(3)), 1'($urandom), $urandom_range(99) < 30,
               5'($urandom_range(3)), 1'($urandom),
               5'($urandom_range(3)), 1'($urandom));
         out_ready = $urandom_range(99) < 70;
         flush = $urandom_range(99) < 3;
         cycle();
      end
      idle();
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (10) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idex_skid_stage.md
# idex_skid_stage

Parametrised decode-to-execute pipeline stage that replaces the fixed-width stall/flush ID/EX register with a valid/ready handshake. It includes a two-entry skid buffer and a built-in load-use interlock. It sits between decode, which packs the control and operand bus into `in_payload`, and execute, which consumes the output entry. Backpressure is decoupled so `in_ready` is driven from a flop. Dependent instructions are held for a parameterised number of bubble cycles after a load leaves the stage.

## Interface
- PAYLOAD_WIDTH, 160: width of the opaque decoded bus (EX/MA/WB control, operands, immediate, PC, IC).
- RADDR_WIDTH, 5: register-address width.
- LOAD_BUBBLES, 1: bubbles inserted between a load and a dependent instruction; legal range 0..7, and 0 disables the interlock.
- Clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  decode offers an entry.
- in_ready  out  1  stage can accept an entry.
- in_payload  in  PAYLOAD_WIDTH  decoded bus.
- in_rd  in  RADDR_WIDTH  destination register.
- in_rd_we  in  1  destination is written.
- in_is_load  in  1  instruction is a load.
- in_rs1, in_rs2  in  RADDR_WIDTH each  source registers.
- in_need_rs1, in_need_rs2  in  1 each  source is actually read.
- out_valid  out  1  entry presented to execute.
- out_ready  in  1  execute accepts.
- out_payload, out_rd, out_rd_we, out_is_load  out  widths as inputs  fields of the head entry.
- hazard_stall  out  1  head entry blocked by the load-use interlock.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- **Storage.** Head register M drives all `out_*` fields. Skid register S holds the overflow entry. Each entry is {payload, rd, rd_we, is_load, rs1, rs2, need_rs1, need_rs2} plus a valid bit.
- **Acceptance.**
  - `in_ready = !S_valid`.
  - An input transfer is `in_valid && in_ready && !flush`.
- **Output.**
  - `out_valid = M_valid && !hazard_stall`.
  - An output transfer is `out_valid && out_ready`.
- **Update priority**, evaluated at each edge:
  1. If `flush`: M_valid and S_valid go to 0. Any input offered that cycle is dropped. An output transfer in the same cycle still counts as completed.
  2. Else, if there is an output transfer and S_valid: S moves into M and S_valid goes to 0.
  3. Else, if there is an input transfer: the entry goes into M when M is empty or leaving this cycle; otherwise it goes into S.
  4. Else, if there is an output transfer: M_valid goes to 0.
- **Load tracking.** On an output transfer with `out_is_load && out_rd_we && out_rd != 0`:
  - `ld_rd <= out_rd`.
  - `ld_cnt <= LOAD_BUBBLES`.
  - Otherwise `ld_cnt` decrements by 1 per cycle and saturates at 0.
  - `flush` does not touch `ld_rd` or `ld_cnt`, because the load is older than the flush.
- **Hazard.** `hazard_stall = M_valid && ld_cnt != 0 && ((M_need_rs1 && M_rs1 == ld_rd) || (M_need_rs2 && M_rs2 == ld_rd))`.
- **Register 0.** Register 0 never creates a hazard.
- **Occupancy.** `occupancy = M_valid + S_valid`.

## Timing
- **Reset values.**
  - M_valid, S_valid, ld_cnt, ld_rd and all entry fields are 0.
  - Hence `out_valid=0`, `in_ready=1`, `hazard_stall=0`, `occupancy=0`, and all `out_*` fields are 0.
- **Latency and throughput.**
  - Latency from input transfer to `out_valid` is 1 cycle when empty.
  - Sustained throughput is 1 entry per cycle with `out_ready` held at 1.
- **Skid behaviour.**
  - When `out_ready` drops, the stage absorbs exactly one more entry into S.
  - `in_ready` falls in the cycle after S fills.
  - `in_ready` rises in the cycle after S drains.
- **Combinational paths.** `in_ready` has no combinational path from any input. `out_valid` and `hazard_stall` are functions of flops only.
- **Interlock timing.** Load transferred at cycle t, dependent instruction in M from t+1: `out_valid` is 0 for cycles t+1..t+LOAD_BUBBLES and 1 at t+LOAD_BUBBLES+1.
- **Load re-arm.** A second load transferring while `ld_cnt != 0` re-arms the counter with its own rd.
- **Reset mid-operation.** Asynchronous assertion clears all state immediately, and outputs take reset values within the same cycle. Deassertion is synchronised externally and is not filtered in this block.

## Test plan
- **Streaming.** Stream 8 entries with payloads 1..8, `out_ready=1`, no loads → outputs 1..8 on consecutive cycles, first one cycle after the first input transfer, `occupancy ≤ 1`.
- **Backpressure.** Drop `out_ready` for 3 cycles while `in_valid=1` → occupancy reaches 2, `in_ready=0` from the next cycle, no entry lost or duplicated, order preserved.
- **Interlock, LOAD_BUBBLES=1.** Load rd=5, then add with rs1=5 and `need_rs1=1` → one cycle of `out_valid=0`/`hazard_stall=1`, then the add issues.
- **Interlock, LOAD_BUBBLES=3.** Same pair → 3 bubbles.
- **Interlock exclusions.**
  - rd=0 load, then rs1=0 → no bubble.
  - Dependent source with `need_rs1=0` → no bubble.
- **Flush.** Assert `flush` with occupancy 2 and `in_valid=1` → next cycle `occupancy=0`, `out_valid=0`, offered entry absent. A load transferred before the flush still stalls a post-flush dependent.
- **Reset.** Assert reset low mid-stream with occupancy 2 and `ld_cnt=1` → outputs immediately take reset values. After release, the first new entry appears 1 cycle after acceptance with no hazard.
